bytes_to_word: RTL and testbench
================================

# bytes_to_word

Packs a byte stream into fixed-width words over valid/ready handshakes. It is the receive-side counterpart of the word serializer: the first byte accepted lands in `word_data[7:0]`, the LSB-first order in which the serializer emits bytes. It sits between byte-wide sources (UART RX, SPI, FIFOs) and word-wide consumers (register files, memory writers). A registered output stage lets the block sustain one byte per clock while a finished word waits to be taken.

## Interface
Parameters:
- `BYTES_PER_WORD`, 4, bytes per output word; must be ≥ 1.
- `WORD_SIZE`, 8*`BYTES_PER_WORD`, output word width; not overridden independently.
- `CW`, $clog2(`BYTES_PER_WORD`+1), width of `word_count`; derived.

Ports:
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `byte_valid`  input  1  source has a byte.
- `byte_ready`  output  1  block accepts a byte this cycle.
- `byte_data`  input  8  byte payload.
- `byte_last`  input  1  byte ends a packet; flushes a partial word. Honoured only with `BYTES_TO_WORD_LAST_EN`.
- `word_valid`  output  1  assembled word available.
- `word_ready`  input  1  consumer takes the word.
- `word_data`  output  `WORD_SIZE`  assembled word; unfilled bytes are 0.
- `word_count`  output  `CW`  number of valid bytes in `word_data`, from 1 to `BYTES_PER_WORD`.
- `word_last`  output  1  word was closed by `byte_last`.

## Operation
- A byte transfer occurs when `byte_valid && byte_ready`. A word transfer occurs when `word_valid && word_ready`.
- Internal state:
  - accumulator `acc` (`WORD_SIZE` bits);
  - index `idx` (0..`BYTES_PER_WORD`-1);
  - output register holding `word_data`, `word_count` and `word_last`, plus an occupancy flag that drives `word_valid`.
- Each byte transfer writes `byte_data` into byte lane `idx` of the assembled word.
- A byte transfer *closes* the word when `idx == BYTES_PER_WORD-1`, or when `byte_last == 1` and the feature is enabled.
- On close:
  - the output register loads the assembled word, including the current byte, and `word_count = idx+1`;
  - `word_last` loads `byte_last` if enabled, otherwise 0;
  - `word_valid` goes to 1;
  - `acc` clears to 0 and `idx` clears to 0.
- Without close, `idx` increments and `acc` keeps the byte.
- `byte_ready = !word_valid || word_ready`. This is a combinational path from `word_ready`, and it is permitted. `byte_ready` does not depend on `byte_valid`, `byte_data` or `byte_last`.
- A word transfer without a simultaneous close clears `word_valid`. A word transfer in the same cycle as a close loads the new word, and `word_valid` stays 1.
- Stall: while `word_valid=1 && word_ready=0`:
  - `byte_ready=0`, even for bytes that would not close a word;
  - `word_data`, `word_count` and `word_last` hold stable.
- `BYTES_PER_WORD == 1`: every byte closes a word, and `idx` is constant 0.
- `byte_last` on the first byte of a word produces `word_count=1`. A packet of zero bytes cannot be expressed.

## Timing
- Reset values (async, while `rst==0`): `word_valid=0`, `word_data=0`, `word_count=0`, `word_last=0`, `acc=0`, `idx=0`. Consequently `byte_ready=1`.
- Reset asserted mid-word discards the partial accumulator and any pending output word. No word is emitted.
- Latency: `word_valid` rises on the clock edge that accepts the closing byte. The word is visible in the following cycle.
- Throughput: 1 byte/cycle sustained when `word_ready` is held at 1. A full word every `BYTES_PER_WORD` cycles, with no bubbles.
- Handshake rules, both ports: `word_valid` and the word outputs never change while `word_valid && !word_ready`. The source must follow the same rule on the byte port.

## Configuration
- `BYTES_TO_WORD_LAST_EN` defined:
  - `byte_last` closes partial words;
  - `word_count` reports the valid bytes in the word;
  - `word_last` mirrors the `byte_last` that closed the word.
- Not defined:
  - `byte_last` is ignored, and no logic is built for it;
  - every emitted word is full;
  - `word_count = BYTES_PER_WORD` whenever `word_valid=1` (0 in reset);
  - `word_last` is constant 0.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with `word_ready=1` -> one cycle after the 0x44 transfer, `word_valid=1`, `word_data=0x44332211`, `word_count=4`, `word_last=0`.
- Continuous stream 0x00..0x0F with `word_ready=1` -> four words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. `byte_ready` stays 1 throughout.
- Backpressure: complete word 0xDDCCBBAA, hold `word_ready=0` for 5 cycles -> `byte_ready=0`, outputs stable for all 5 cycles. Releasing `word_ready` gives a word transfer and `byte_ready=1` in the same cycle.
- With `BYTES_TO_WORD_LAST_EN`: 0xA1,0xB2 with `byte_last=1` on 0xB2 -> `word_data=0x0000B2A1`, `word_count=2`, `word_last=1`. The next byte 0xC3 starts at lane 0.
- Without `BYTES_TO_WORD_LAST_EN`: the same stimulus produces no word until two more bytes arrive. `word_last` stays 0.
- Drive `rst=0` for one cycle asynchronously after 3 bytes, then send 0x01..0x04 -> the first word is 0x04030201, with no residue from the aborted word.

Source files
------------

// File: rtl/bytes_to_word.sv
// Packs an LSB-first byte stream into BYTES_PER_WORD-byte words. Optional: BYTES_TO_WORD_LAST_EN (byte_last flushes partial words).
// Latency: word_valid rises on the edge that accepts the closing byte; sustains one byte per clock.
// Backpressure: byte_ready = !word_valid || word_ready; the output word holds stable while stalled.
module bytes_to_word #(
    parameter int BYTES_PER_WORD = 4,
    parameter int WORD_SIZE      = 8 * BYTES_PER_WORD,
    parameter int CW             = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [WORD_SIZE-1:0] word_data,
    output logic [CW-1:0]        word_count,
    output logic                 word_last
);

    localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 vld_q, vld_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [WORD_SIZE-1:0] assembled;
    logic                 fire;
    logic                 last_hit;
    logic                 close;

`ifdef BYTES_TO_WORD_LAST_EN
    assign last_hit = byte_last;
`else
    // byte_last is deliberately left dangling so nothing is built for it.
    logic unused_byte_last;
    assign unused_byte_last = byte_last;
    assign last_hit         = 1'b0;
`endif

    assign byte_ready = !vld_q || word_ready;
    assign fire       = byte_valid && byte_ready;
    assign close      = fire && ((idx_q == IW'(BYTES_PER_WORD - 1)) || last_hit);

    always_comb begin
        assembled = acc_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx_q == IW'(i)) begin
                assembled[i*8 +: 8] = byte_data;
            end
        end
    end

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (vld_q && word_ready) begin
            vld_d = 1'b0;
        end
        if (close) begin
            // A close in the same cycle as a word transfer reloads the output and keeps it valid.
            data_d = assembled;
            cnt_d  = CW'(idx_q) + CW'(1);
            last_d = last_hit;
            vld_d  = 1'b1;
            acc_d  = '0;
            idx_d  = '0;
        end else if (fire) begin
            acc_d = assembled;
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign word_valid = vld_q;
    assign word_data  = data_q;
    assign word_count = cnt_q;
`ifdef BYTES_TO_WORD_LAST_EN
    assign word_last  = last_q;
`else
    assign word_last  = 1'b0;
`endif

endmodule

// File: tb/tb_bytes_to_word.sv
// Scoreboard bench for bytes_to_word: stimulus pushes expected words, a negedge monitor pops on each word transfer.
module tb_bytes_to_word;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [2:0]  word_count;
    logic        word_last;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   stall_total = 0;
    int   cyc = 0;

    bytes_to_word #(.BYTES_PER_WORD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_count (word_count),
        .word_last  (word_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] c, input logic l);
        exp_t e;
        e.data  = d;
        e.count = c;
        e.last  = l;
        exp_q.push_back(e);
    endtask

    // Present one byte, wait (bounded) for acceptance, leave inputs settled 1ns after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        @(negedge clk);
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: byte 0x%0h not accepted", d);
        end
        stall_total += n;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Monitor: every word transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_word: got 0x%0h with no expectation", word_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data",  64'(word_data),  64'(e.data));
                chk("word_count", 64'(word_count), 64'(e.count));
                chk("word_last",  64'(word_last),  64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        word_ready = 1'b1;
        #12;
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_word_data",  64'(word_data),  64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_word_last",  64'(word_last),  64'd0);
        chk("rst_byte_ready", 64'(byte_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic word and its latency
        push(32'h44332211, 3'd4, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("early_valid", 64'(word_valid), 64'd0);
        send(8'h44, 1'b0);
        chk("latency_valid", 64'(word_valid), 64'd1);
        chk("latency_data",  64'(word_data),  64'h44332211);
        @(posedge clk);
        #1;

        // Back-to-back stream, no bubbles
        push(32'h03020100, 3'd4, 1'b0);
        push(32'h07060504, 3'd4, 1'b0);
        push(32'h0B0A0908, 3'd4, 1'b0);
        push(32'h0F0E0D0C, 3'd4, 1'b0);
        stall_total = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        chk("stream_stalls", 64'(stall_total), 64'd0);
        chk("stream_cycles", 64'(cyc - c0), 64'd16);
        @(posedge clk);
        #1;

        // Backpressure: word held stable, bytes blocked
        word_ready = 1'b0;
        push(32'hDDCCBBAA, 3'd4, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_byte_ready", 64'(byte_ready), 64'd0);
            chk("stall_valid",      64'(word_valid), 64'd1);
            chk("stall_data",       64'(word_data),  64'hDDCCBBAA);
            chk("stall_count",      64'(word_count), 64'd4);
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        #1;
        chk("release_byte_ready", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("release_cleared", 64'(word_valid), 64'd0);

        // byte_last handling
`ifdef BYTES_TO_WORD_LAST_EN
        push(32'h0000B2A1, 3'd2, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        chk("last_valid", 64'(word_valid), 64'd1);
        push(32'hF6E5D4C3, 3'd4, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hD4, 1'b0);
        send(8'hE5, 1'b0);
        send(8'hF6, 1'b0);
`else
        push(32'hD4C3B2A1, 3'd4, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        chk("last_ignored_valid", 64'(word_valid), 64'd0);
        send(8'hC3, 1'b0);
        send(8'hD4, 1'b0);
        chk("last_ignored_wlast", 64'(word_last), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Async reset mid-word discards the partial word
        send(8'h99, 1'b0);
        send(8'h98, 1'b0);
        send(8'h97, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_valid", 64'(word_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(32'h04030201, 3'd4, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
